min_offset_sub: RTL and testbench

Row offset stage that consumes the minimum produced by the attention datapath's find-min block. It latches one packed row of `N` signed elements plus that row's minimum, subtracts the minimum from every element, and streams the non-negative offsets out one per cycle under a valid/ready handshake. It can optionally also accumulate the row sum. It sits between the min-finder and the downstream normalisation/exponent stage.

---
 rtl/attn_pkg.sv | 17 +
 rtl/clamp_sub.sv | 16 +
 rtl/min_offset_sub.sv | 120 ++++++++++++
 tb/tb_min_offset_sub.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/attn_pkg.sv
// rtl/attn_pkg.sv - shared defaults, row-stage FSM encoding and index width helper
package attn_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int N_DEF      = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FIN    = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clamp_sub.sv
// rtl/clamp_sub.sv - signed W-bit subtract a-b, clamped at zero, unsigned W-bit result
module clamp_sub #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    // One extra bit holds the full signed range of a-b; its MSB flags a < b.
    logic [W:0] diff;

    assign diff = {a[W-1], a} - {b[W-1], b};
    assign y    = diff[W] ? '0 : diff[W-1:0];

endmodule

// File: rtl/min_offset_sub.sv
// rtl/min_offset_sub.sv - latches a row and its minimum, streams clamped offsets; ROW_SUM_EN adds row_sum
module min_offset_sub
    import attn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N      = N_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [N*DATA_W-1:0]           numbers,
    input  logic [DATA_W-1:0]             min_val,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(N)-1:0]          out_idx,
    output logic                          done
`ifdef ROW_SUM_EN
    ,
    output logic [DATA_W+$clog2(N)-1:0]   row_sum
`endif
);

    localparam int IW = idx_w(N);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   row_q [N];
    logic [DATA_W-1:0]   min_q;
    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       nidx;
    logic [DATA_W-1:0]   sub_a;
    logic [DATA_W-1:0]   sub_b;
    logic [DATA_W-1:0]   offset;
    logic                hs;
    logic                last;

    assign hs   = (state_q == STREAM) && out_ready;
    assign last = (idx_q == IW'(N - 1));
    assign nidx = idx_q + 1'b1;

    // In IDLE the subtractor looks at the incoming row so element 0 is ready
    // in the first STREAM cycle; afterwards it prepares the next element.
    assign sub_a = (state_q == IDLE) ? numbers[DATA_W-1:0] : row_q[nidx];
    assign sub_b = (state_q == IDLE) ? min_val : min_q;

    clamp_sub #(.W(DATA_W)) u_clamp_sub (
        .a (sub_a),
        .b (sub_b),
        .y (offset)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = STREAM;
            STREAM:  if (hs && last) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) row_q[i] <= '0;
            min_q    <= '0;
            idx_q    <= '0;
            out_data <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) row_q[i] <= numbers[i*DATA_W +: DATA_W];
                        min_q    <= min_val;
                        idx_q    <= '0;
                        out_data <= offset;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        if (last) begin
                            idx_q    <= '0;
                            out_data <= '0;
                        end else begin
                            idx_q    <= nidx;
                            out_data <= offset;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ROW_SUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_sum <= '0;
        end else if (state_q == IDLE && start) begin
            row_sum <= '0;
        end else if (hs) begin
            row_sum <= row_sum + (DATA_W+IW)'(out_data);
        end
    end
`endif

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == STREAM);
    assign done      = (state_q == FIN);
    assign out_idx   = idx_q;

endmodule

// File: tb/tb_min_offset_sub.sv
// tb/tb_min_offset_sub.sv - self-checking bench for min_offset_sub with a queue-based reference model
module tb_min_offset_sub;

    localparam int DW = 16;
    localparam int NN = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [NN*DW-1:0]  numbers;
    logic [DW-1:0]     min_val;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [2:0]        out_idx;
    logic              done;
`ifdef ROW_SUM_EN
    logic [DW+2:0]     row_sum;
`endif

    min_offset_sub #(.DATA_W(DW), .N(NN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .numbers   (numbers),
        .min_val   (min_val),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .done      (done)
`ifdef ROW_SUM_EN
        ,
        .row_sum   (row_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int off_of(input logic [NN*DW-1:0] nums, input logic [DW-1:0] mn, input int i);
        logic signed [DW-1:0] e;
        logic signed [DW-1:0] m;
        int d;
        e = nums[i*DW +: DW];
        m = mn;
        d = int'(e) - int'(m);
        return (d < 0) ? 0 : d;
    endfunction

    function automatic logic [NN*DW-1:0] pack8(input int v[NN]);
        logic [NN*DW-1:0] r;
        for (int i = 0; i < NN; i++) r[i*DW +: DW] = DW'(v[i]);
        return r;
    endfunction

    // Reference model: a row becomes a queue of pending offsets, then one done cycle.
    int m_q[$];
    bit m_fin = 1'b0;
    int m_sum = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_fin = 1'b0;
                m_sum = 0;
            end else if (m_fin) begin
                m_fin = 1'b0;
            end else if (m_q.size() > 0) begin
                if (out_ready) begin
                    m_sum += m_q.pop_front();
                    if (m_q.size() == 0) m_fin = 1'b1;
                end
            end else if (start) begin
                m_sum = 0;
                for (int i = 0; i < NN; i++) m_q.push_back(off_of(numbers, min_val, i));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("busy", busy, (m_q.size() > 0) || m_fin);
            chk("out_valid", out_valid, m_q.size() > 0);
            chk("done", done, m_fin);
            if (m_q.size() > 0) begin
                chk("out_data", out_data, m_q[0]);
                chk("out_idx", out_idx, NN - m_q.size());
            end
`ifdef ROW_SUM_EN
            else chk("row_sum", row_sum, m_sum);
`endif
        end
    end

    int v_basic[NN] = '{3, -2, 7, 0, -2, 10, 1, 4};
    int e_basic[NN] = '{5, 0, 9, 2, 0, 12, 3, 6};
    int v_ext[NN]   = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    int e_ext[NN]   = '{65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535};
    int v_bad[NN]   = '{4, 1, 5, 9, 4, 100, 7, 20};
    int e_bad[NN]   = '{0, 0, 1, 5, 0, 96, 3, 16};

    // Drives one row from IDLE, checks each element against exp_v, returns the done cycle.
    task automatic run_row(input logic [NN*DW-1:0] nums, input logic [DW-1:0] mn, input int exp_v[NN],
                           input int stall_s, input int stall_len, input int busy_c, output int done_c);
        int k;
        @(negedge clk);
        numbers   = nums;
        min_val   = mn;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        k = 0;
        done_c = -1;
        for (int c = 1; c < 60 && done_c < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < NN; i++) numbers[i*DW +: DW] = DW'($urandom);
            min_val = DW'($urandom);
            if (c == busy_c) start = 1'b1;
            if (out_valid) begin
                chk("row_idx", out_idx, k);
                chk("row_data", out_data, (k < NN) ? exp_v[k] : -1);
            end
            out_ready = !(stall_len > 0 && c >= stall_s && c < stall_s + stall_len);
            if (out_valid && out_ready) k++;
            if (done) done_c = c;
        end
        if (done_c < 0) chk("row_done_timeout", 0, 1);
    endtask

    int dc;
    int mn_i;

    initial begin
        rst_n = 1'b0; start = 1'b0; numbers = '0; min_val = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_row(pack8(v_basic), 16'hFFFE, e_basic, 0, 0, 0, dc);
        chk("basic_done_cycle", dc, 9);
`ifdef ROW_SUM_EN
        chk("basic_row_sum", row_sum, 37);
`endif

        run_row(pack8(v_ext), 16'h8000, e_ext, 0, 0, 0, dc);
        chk("extreme_done_cycle", dc, 9);
`ifdef ROW_SUM_EN
        chk("extreme_row_sum", row_sum, 19'h7FFF8);
`endif

        run_row(pack8(v_basic), 16'hFFFE, e_basic, 3, 3, 0, dc);
        chk("stall_done_cycle", dc, 12);

        run_row(pack8(v_basic), 16'hFFFE, e_basic, 0, 0, 5, dc);
        chk("busy_start_done_cycle", dc, 9);
        @(negedge clk);
        chk("busy_start_ignored", busy, 0);

        run_row(pack8(v_bad), 16'd4, e_bad, 0, 0, 0, dc);
        chk("badmin_done_cycle", dc, 9);

        // Reset in the middle of a row, while element 5 is presented.
        @(negedge clk);
        numbers = pack8(v_basic); min_val = 16'hFFFE; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_idx", out_idx, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_data", out_data, 0);
        chk("async_rst_idx", out_idx, 0);
`ifdef ROW_SUM_EN
        chk("async_rst_sum", row_sum, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_row(pack8(v_basic), 16'hFFFE, e_basic, 0, 0, 0, dc);
        chk("post_reset_done_cycle", dc, 9);

        // Randomised traffic, checked every cycle by the model.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < NN; i++) numbers[i*DW +: DW] = DW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                mn_i = 32767;
                for (int i = 0; i < NN; i++)
                    if (int'($signed(numbers[i*DW +: DW])) < mn_i) mn_i = int'($signed(numbers[i*DW +: DW]));
                min_val = DW'(mn_i);
            end else begin
                min_val = DW'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
